// File: rtl/match_pkg.sv
// match_pkg
// Shared encodings and constants for the two-fighter match controller.
//   phase_e   : renderer-visible round phase (IDLE..GAME_OVER)
//   winner_e  : round result reported once the round ends
//   DMG_*     : health removed by a normal or directional attack
//   ROUND_*   : round-timer length, used only when MATCH_ROUND_TIMER_EN is defined
//   satSub    : health subtraction that stops at zero
package match_pkg;

   typedef enum logic [2:0] {
      PH_IDLE      = 3'd0,
      PH_COUNTDOWN = 3'd1,
      PH_FIGHT     = 3'd2,
      PH_KO        = 3'd3,
      PH_GAME_OVER = 3'd4
   } phase_e;

   typedef enum logic [1:0] {
      WIN_NONE = 2'd0,
      WIN_P1   = 2'd1,
      WIN_P2   = 2'd2,
      WIN_DRAW = 2'd3
   } winner_e;

   localparam logic [1:0] DMG_NORMAL = 2'd1;
   localparam logic [1:0] DMG_DIR    = 2'd2;

   localparam int FRAMES_PER_SEC = 60;
   localparam int ROUND_FRAMES   = 5940;
   localparam int ROUND_SECONDS  = ROUND_FRAMES / FRAMES_PER_SEC;

   // Health never wraps: a 2-damage hit on 1 health leaves 0.
   function automatic logic [1:0] satSub(input logic [1:0] health, input logic [1:0] dmg);
      return (health > dmg) ? (health - dmg) : 2'd0;
   endfunction

endpackage

// File: rtl/match_controller_stun_timer.sv
// stun_timer
// Per-player stun generator. A hit or block load restarts the countdown
// (never extends it); a hit wins when both loads arrive together.
// Ports:
//   clk, reset        frame clock, synchronous active-high reset
//   clear_i           drop any stun immediately (round ended)
//   hit_i, block_i    load hitstun / blockstun length
//   hitstun_o         high for HIT_LEN frames after a hit load
//   blkstun_o         high for BLK_LEN frames after a block load
module stun_timer #(
   parameter int HIT_LEN = 16,
   parameter int BLK_LEN = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic hit_i,
   input  logic block_i,
   output logic hitstun_o,
   output logic blkstun_o
);

   localparam int CntW = $clog2(((HIT_LEN > BLK_LEN) ? HIT_LEN : BLK_LEN) + 1);
   localparam logic [CntW-1:0] HitLoad = CntW'(HIT_LEN - 1);
   localparam logic [CntW-1:0] BlkLoad = CntW'(BLK_LEN - 1);

   logic [CntW-1:0] count_q;
   logic            hitstun_q;
   logic            blkstun_q;

   // The counter holds the frames remaining after the current one, so the
   // flag stays up for the full length: it drops on the frame after the
   // counter has already reached zero.
   always_ff @(posedge clk) begin
      if (reset || clear_i) begin
         count_q   <= '0;
         hitstun_q <= 1'b0;
         blkstun_q <= 1'b0;
      end else if (hit_i) begin
         count_q   <= HitLoad;
         hitstun_q <= 1'b1;
         blkstun_q <= 1'b0;
      end else if (block_i) begin
         count_q   <= BlkLoad;
         hitstun_q <= 1'b0;
         blkstun_q <= 1'b1;
      end else if (count_q != '0) begin
         count_q <= count_q - 1'b1;
      end else begin
         hitstun_q <= 1'b0;
         blkstun_q <= 1'b0;
      end
   end

   assign hitstun_o = hitstun_q;
   assign blkstun_o = blkstun_q;

endmodule

// File: rtl/match_controller.sv
// match_controller
// Round sequencer and hit arbiter for the two-fighter game, one step per
// 60 Hz frame. Resolves each attack at most once, applies damage or block,
// requests stun, and walks IDLE -> COUNTDOWN -> FIGHT -> KO -> GAME_OVER.
// Optional feature macro: MATCH_ROUND_TIMER_EN adds a 99 s round timer and
// the timer_sec output.
// Ports:
//   clk, reset                 frame clock, synchronous active-high reset
//   start                      start/restart button (level)
//   p1_x, p2_x                 sprite left X, P1 always left of P2
//   p*_act, p*_dir, p*_block   attack-active, directional attack, blocking
//   play_active                fighters may accept input (FIGHT only)
//   phase                      current phase_e encoding
//   p1_health, p2_health       remaining health
//   p*_hitstun, p*_blkstun     stun requests to the fighter FSMs
//   winner                     winner_e encoding
//   timer_sec                  seconds left (only with MATCH_ROUND_TIMER_EN)
module match_controller import match_pkg::*; #(
   parameter int SPRITE_W         = 64,
   parameter int REACH            = 32,
   parameter int MAX_HEALTH       = 3,
   parameter int COUNTDOWN_FRAMES = 180,
   parameter int KO_FRAMES        = 120,
   parameter int HITSTUN_FRAMES   = 16,
   parameter int BLOCKSTUN_FRAMES = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [9:0] p1_x,
   input  logic [9:0] p2_x,
   input  logic       p1_act,
   input  logic       p2_act,
   input  logic       p1_dir,
   input  logic       p2_dir,
   input  logic       p1_block,
   input  logic       p2_block,
   output logic       play_active,
   output logic [2:0] phase,
   output logic [1:0] p1_health,
   output logic [1:0] p2_health,
   output logic       p1_hitstun,
   output logic       p2_hitstun,
   output logic       p1_blkstun,
   output logic       p2_blkstun,
   output logic [1:0] winner
`ifdef MATCH_ROUND_TIMER_EN
   ,
   output logic [6:0] timer_sec
`endif
);

   localparam logic [10:0] ReachSpan = 11'(SPRITE_W + REACH);
   localparam int CntW = $clog2(((COUNTDOWN_FRAMES > KO_FRAMES) ? COUNTDOWN_FRAMES : KO_FRAMES) + 1);
   localparam logic [CntW-1:0] CdLast = CntW'(COUNTDOWN_FRAMES - 1);
   localparam logic [CntW-1:0] KoLast = CntW'(KO_FRAMES - 1);
   localparam logic [1:0] FullHealth = 2'(MAX_HEALTH);

   phase_e          phase_q;
   winner_e         winner_q;
   logic [CntW-1:0] frameCnt_q;
   logic            playActive_q;
   logic [1:0]      p1Health_q;
   logic [1:0]      p2Health_q;
   logic            p1HitDone_q;
   logic            p2HitDone_q;

   logic       inFight;
   logic       inRange;
   logic       koNow;
   logic       koEnter;
   logic       p1Conn;
   logic       p2Conn;
   logic [1:0] p1Dmg;
   logic [1:0] p2Dmg;

`ifdef MATCH_ROUND_TIMER_EN
   localparam logic [6:0] TimerStart = 7'(ROUND_SECONDS);
   localparam logic [5:0] SecLast    = 6'(FRAMES_PER_SEC - 1);
   logic [6:0] timerSec_q;
   logic [5:0] secFrame_q;
   logic       timerExpire;
`endif

   // Hit geometry and the round-ending conditions. Both attackers use the
   // same gap test because P1 is always on the left; widening to 11 bits
   // keeps the right edge from wrapping near the screen edge. A round that
   // is ending this frame resolves no further connects.
   always_comb begin
      inFight = (phase_q == PH_FIGHT);
      inRange = (({1'b0, p1_x} + ReachSpan) >= {1'b0, p2_x});
      koNow   = inFight && ((p1Health_q == 2'd0) || (p2Health_q == 2'd0));
`ifdef MATCH_ROUND_TIMER_EN
      timerExpire = inFight && (timerSec_q == 7'd0);
      koEnter     = koNow || timerExpire;
`else
      koEnter     = koNow;
`endif
      p1Conn = inFight && !koEnter && p1_act && !p1HitDone_q && inRange;
      p2Conn = inFight && !koEnter && p2_act && !p2HitDone_q && inRange;
      p1Dmg  = p1_dir ? DMG_DIR : DMG_NORMAL;
      p2Dmg  = p2_dir ? DMG_DIR : DMG_NORMAL;
   end

   // Phase sequencing, health bookkeeping and the one-hit-per-attack
   // latches. KO is taken from the registered healths, so the phase moves
   // one frame after the killing blow shows up on the health outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         phase_q      <= PH_IDLE;
         winner_q     <= WIN_NONE;
         frameCnt_q   <= '0;
         playActive_q <= 1'b0;
         p1Health_q   <= FullHealth;
         p2Health_q   <= FullHealth;
         p1HitDone_q  <= 1'b0;
         p2HitDone_q  <= 1'b0;
`ifdef MATCH_ROUND_TIMER_EN
         timerSec_q   <= TimerStart;
         secFrame_q   <= '0;
`endif
      end else begin
         if (!p1_act)     p1HitDone_q <= 1'b0;
         else if (p1Conn) p1HitDone_q <= 1'b1;
         if (!p2_act)     p2HitDone_q <= 1'b0;
         else if (p2Conn) p2HitDone_q <= 1'b1;

         case (phase_q)
            PH_IDLE, PH_GAME_OVER: begin
               if (start) begin
                  phase_q    <= PH_COUNTDOWN;
                  frameCnt_q <= '0;
                  p1Health_q <= FullHealth;
                  p2Health_q <= FullHealth;
                  winner_q   <= WIN_NONE;
`ifdef MATCH_ROUND_TIMER_EN
                  timerSec_q <= TimerStart;
                  secFrame_q <= '0;
`endif
               end
            end
            PH_COUNTDOWN: begin
               if (frameCnt_q == CdLast) begin
                  phase_q      <= PH_FIGHT;
                  playActive_q <= 1'b1;
                  frameCnt_q   <= '0;
               end else begin
                  frameCnt_q <= frameCnt_q + 1'b1;
               end
            end
            PH_FIGHT: begin
               if (koNow) begin
                  phase_q      <= PH_KO;
                  playActive_q <= 1'b0;
                  frameCnt_q   <= '0;
                  if ((p1Health_q == 2'd0) && (p2Health_q == 2'd0)) winner_q <= WIN_DRAW;
                  else if (p1Health_q == 2'd0)                      winner_q <= WIN_P2;
                  else                                              winner_q <= WIN_P1;
               end
`ifdef MATCH_ROUND_TIMER_EN
               else if (timerExpire) begin
                  phase_q      <= PH_KO;
                  playActive_q <= 1'b0;
                  frameCnt_q   <= '0;
                  if (p1Health_q > p2Health_q)      winner_q <= WIN_P1;
                  else if (p2Health_q > p1Health_q) winner_q <= WIN_P2;
                  else                              winner_q <= WIN_DRAW;
               end
`endif
               else begin
                  if (p1Conn && !p2_block) p2Health_q <= satSub(p2Health_q, p1Dmg);
                  if (p2Conn && !p1_block) p1Health_q <= satSub(p1Health_q, p2Dmg);
`ifdef MATCH_ROUND_TIMER_EN
                  if (secFrame_q == SecLast) begin
                     secFrame_q <= '0;
                     timerSec_q <= timerSec_q - 1'b1;
                  end else begin
                     secFrame_q <= secFrame_q + 1'b1;
                  end
`endif
               end
            end
            PH_KO: begin
               if (frameCnt_q == KoLast) begin
                  phase_q    <= PH_GAME_OVER;
                  frameCnt_q <= '0;
               end else begin
                  frameCnt_q <= frameCnt_q + 1'b1;
               end
            end
            default: phase_q <= PH_IDLE;
         endcase
      end
   end

   // Each defender's stun follows the opponent's connect; blocking turns
   // the hit into blockstun. Both timers drop immediately when the round ends.
   stun_timer #(
      .HIT_LEN (HITSTUN_FRAMES),
      .BLK_LEN (BLOCKSTUN_FRAMES)
   ) u_p1Stun (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (koEnter),
      .hit_i     (p2Conn && !p1_block),
      .block_i   (p2Conn && p1_block),
      .hitstun_o (p1_hitstun),
      .blkstun_o (p1_blkstun)
   );

   stun_timer #(
      .HIT_LEN (HITSTUN_FRAMES),
      .BLK_LEN (BLOCKSTUN_FRAMES)
   ) u_p2Stun (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (koEnter),
      .hit_i     (p1Conn && !p2_block),
      .block_i   (p1Conn && p2_block),
      .hitstun_o (p2_hitstun),
      .blkstun_o (p2_blkstun)
   );

   assign play_active = playActive_q;
   assign phase       = phase_q;
   assign p1_health   = p1Health_q;
   assign p2_health   = p2Health_q;
   assign winner      = winner_q;
`ifdef MATCH_ROUND_TIMER_EN
   assign timer_sec   = timerSec_q;
`endif

endmodule

// File: tb/tb_match_controller.sv
// tb_match_controller
// Directed bench for match_controller in its default build. Stimulus
// schedules expected output snapshots for specific future frames; an
// independent monitor compares them on the falling edge of that frame.
module tb_match_controller;

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] CD   = 3'd1;
   localparam logic [2:0] FGT  = 3'd2;
   localparam logic [2:0] KO   = 3'd3;
   localparam logic [2:0] GO   = 3'd4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [9:0] p1_x = 10'd100;
   logic [9:0] p2_x = 10'd190;
   logic       p1_act = 1'b0, p2_act = 1'b0;
   logic       p1_dir = 1'b0, p2_dir = 1'b0;
   logic       p1_block = 1'b0, p2_block = 1'b0;
   logic       play_active;
   logic [2:0] phase;
   logic [1:0] p1_health, p2_health, winner;
   logic       p1_hitstun, p2_hitstun, p1_blkstun, p2_blkstun;

   match_controller dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .p1_x        (p1_x),
      .p2_x        (p2_x),
      .p1_act      (p1_act),
      .p2_act      (p2_act),
      .p1_dir      (p1_dir),
      .p2_dir      (p2_dir),
      .p1_block    (p1_block),
      .p2_block    (p2_block),
      .play_active (play_active),
      .phase       (phase),
      .p1_health   (p1_health),
      .p2_health   (p2_health),
      .p1_hitstun  (p1_hitstun),
      .p2_hitstun  (p2_hitstun),
      .p1_blkstun  (p1_blkstun),
      .p2_blkstun  (p2_blkstun),
      .winner      (winner)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         frame;
      string      name;
      logic [13:0] vec;
   } exp_t;

   exp_t expQ[$];
   int   frameNo    = 0;
   int   compared   = 0;
   int   mismatched = 0;

   // Frame index: bumps on every rising edge, so outputs seen during a
   // frame belong to that frame number.
   always @(posedge clk) frameNo <= frameNo + 1;

   function automatic string fmtVec(input logic [13:0] v);
      return $sformatf("ph=%0d pa=%0b h=%0d/%0d hs=%0b%0b bs=%0b%0b w=%0d",
                       v[13:11], v[10], v[9:8], v[7:6], v[5], v[4], v[3], v[2], v[1:0]);
   endfunction

   // Monitor: on the falling edge, compare every expectation due this frame.
   always @(negedge clk) begin
      logic [13:0] act;
      int i;
      act = {phase, play_active, p1_health, p2_health,
             p1_hitstun, p2_hitstun, p1_blkstun, p2_blkstun, winner};
      i = 0;
      while (i < expQ.size()) begin
         if (expQ[i].frame <= frameNo) begin
            compared++;
            if (expQ[i].frame < frameNo || act !== expQ[i].vec) begin
               mismatched++;
               $display("[TB] FAIL %s (frame %0d): got %s, expected %s", expQ[i].name,
                        expQ[i].frame, fmtVec(act), fmtVec(expQ[i].vec));
            end
            expQ.delete(i);
         end else begin
            i++;
         end
      end
   end

   // Advance n frames, landing 1 time unit after the rising edge.
   task automatic advanceFrames(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive the fighter-side inputs for the current frame.
   task automatic applyStimulus(input logic a1, input logic a2, input logic d1, input logic d2,
                                input logic b1, input logic b2);
      p1_act   = a1;
      p2_act   = a2;
      p1_dir   = d1;
      p2_dir   = d2;
      p1_block = b1;
      p2_block = b2;
   endtask

   // Schedule an expected output snapshot `delta` frames from now; a
   // snapshot due this frame is also compared against the live outputs.
   task automatic checkOutput(input string name, input int delta, input logic [2:0] ph,
                              input logic pa, input logic [1:0] h1, input logic [1:0] h2,
                              input logic hs1, input logic hs2, input logic bs1,
                              input logic bs2, input logic [1:0] w);
      exp_t e;
      logic [13:0] live;
      e.frame = frameNo + delta;
      e.name  = name;
      e.vec   = {ph, pa, h1, h2, hs1, hs2, bs1, bs2, w};
      expQ.push_back(e);
      if (delta == 0) begin
         live = {phase, play_active, p1_health, p2_health,
                 p1_hitstun, p2_hitstun, p1_blkstun, p2_blkstun, winner};
         compared++;
         if (live !== e.vec) begin
            mismatched++;
            $display("[TB] FAIL %s (immediate): got %s, expected %s", name,
                     fmtVec(live), fmtVec(e.vec));
         end
      end
   endtask

   // Direct one-signal comparison against the live outputs.
   task automatic expectSig(input string name, input logic [3:0] got, input logic [3:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached, %0d expectations pending", expQ.size());
      $fatal(1, "[TB] watchdog");
   end

   // Directed scenario: one full round ending in a trade, a second round
   // won by P1, then a reset in the middle of a third round.
   initial begin
      advanceFrames(2);
      checkOutput("resetState", 0, IDLE, 0, 3, 3, 0, 0, 0, 0, 0);
      reset = 1'b0;
      advanceFrames(3);
      checkOutput("idleHold", 0, IDLE, 0, 3, 3, 0, 0, 0, 0, 0);
      expectSig("idlePhase", {1'b0, phase}, {1'b0, IDLE});
      expectSig("idlePlay", {3'b0, play_active}, 4'd0);

      start = 1'b1;
      advanceFrames(1);
      start = 1'b0;
      checkOutput("cdEntry", 0, CD, 0, 3, 3, 0, 0, 0, 0, 0);
      expectSig("cdPhase", {1'b0, phase}, {1'b0, CD});
      checkOutput("cdLast", 179, CD, 0, 3, 3, 0, 0, 0, 0, 0);
      checkOutput("fightEntry", 180, FGT, 1, 3, 3, 0, 0, 0, 0, 0);
      advanceFrames(50);
      start = 1'b1;
      advanceFrames(1);
      start = 1'b0;
      advanceFrames(129);

      // P1 normal hit, act held two frames: one hit only.
      applyStimulus(1, 0, 0, 0, 0, 0);
      advanceFrames(1);
      checkOutput("hitLand", 0, FGT, 1, 3, 2, 0, 1, 0, 0, 0);
      checkOutput("hitOnce", 1, FGT, 1, 3, 2, 0, 1, 0, 0, 0);
      checkOutput("hitstunLast", 15, FGT, 1, 3, 2, 0, 1, 0, 0, 0);
      checkOutput("hitstunEnd", 16, FGT, 1, 3, 2, 0, 0, 0, 0, 0);
      advanceFrames(1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      advanceFrames(16);

      // P2 blocks P1's attack.
      applyStimulus(1, 0, 0, 0, 0, 1);
      advanceFrames(1);
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("blkLand", 0, FGT, 1, 3, 2, 0, 0, 0, 1, 0);
      checkOutput("blkLast", 7, FGT, 1, 3, 2, 0, 0, 0, 1, 0);
      checkOutput("blkEnd", 8, FGT, 1, 3, 2, 0, 0, 0, 0, 0);
      advanceFrames(10);
      applyStimulus(0, 0, 0, 0, 0, 0);

      // One pixel beyond reach: 100+64+32 = 196 < 197.
      p2_x = 10'd197;
      applyStimulus(1, 0, 0, 0, 0, 0);
      advanceFrames(1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("outOfReach", 0, FGT, 1, 3, 2, 0, 0, 0, 0, 0);
      checkOutput("outOfReach2", 1, FGT, 1, 3, 2, 0, 0, 0, 0, 0);
      advanceFrames(3);

      // Exactly at reach: P2 directional hit does 2.
      p2_x = 10'd196;
      applyStimulus(0, 1, 0, 1, 0, 0);
      advanceFrames(1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("p2DirHit", 0, FGT, 1, 1, 2, 1, 0, 0, 0, 0);
      checkOutput("p1StunEnd", 16, FGT, 1, 1, 2, 0, 0, 0, 0, 0);
      advanceFrames(18);

      applyStimulus(1, 0, 0, 0, 0, 0);
      advanceFrames(1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("p2To1", 0, FGT, 1, 1, 1, 0, 1, 0, 0, 0);
      advanceFrames(18);

      // Trade at 1/1: draw, then KO for 120 frames, then GAME_OVER.
      applyStimulus(1, 1, 0, 0, 0, 0);
      advanceFrames(1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("tradeHit", 0, FGT, 1, 0, 0, 1, 1, 0, 0, 0);
      checkOutput("koEntry", 1, KO, 0, 0, 0, 0, 0, 0, 0, 3);
      checkOutput("koLast", 120, KO, 0, 0, 0, 0, 0, 0, 0, 3);
      checkOutput("gameOver", 121, GO, 0, 0, 0, 0, 0, 0, 0, 3);
      advanceFrames(125);

      start = 1'b1;
      advanceFrames(1);
      start = 1'b0;
      checkOutput("restart", 0, CD, 0, 3, 3, 0, 0, 0, 0, 0);
      checkOutput("fight2", 180, FGT, 1, 3, 3, 0, 0, 0, 0, 0);
      advanceFrames(180);

      // Start held during FIGHT is ignored; P1 wins by KO.
      start = 1'b1;
      applyStimulus(1, 0, 1, 0, 0, 0);
      advanceFrames(1);
      start = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("dirHitStartIgnored", 0, FGT, 1, 3, 1, 0, 1, 0, 0, 0);
      advanceFrames(2);
      applyStimulus(1, 0, 0, 0, 0, 0);
      advanceFrames(1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("p1Finisher", 0, FGT, 1, 3, 0, 0, 1, 0, 0, 0);
      checkOutput("koWinP1", 1, KO, 0, 3, 0, 0, 0, 0, 0, 1);
      advanceFrames(125);
      checkOutput("goWinP1", 0, GO, 0, 3, 0, 0, 0, 0, 0, 1);
      expectSig("goWinner", {2'b0, winner}, 4'd1);

      start = 1'b1;
      advanceFrames(1);
      start = 1'b0;
      advanceFrames(180);

      // Reset while P2 is in hitstun.
      applyStimulus(1, 0, 0, 0, 0, 0);
      advanceFrames(1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("preReset", 0, FGT, 1, 3, 2, 0, 1, 0, 0, 0);
      advanceFrames(3);
      reset = 1'b1;
      advanceFrames(1);
      reset = 1'b0;
      checkOutput("midReset", 0, IDLE, 0, 3, 3, 0, 0, 0, 0, 0);
      expectSig("midResetStun", {3'b0, p2_hitstun}, 4'd0);
      expectSig("midResetHealth", {2'b0, p2_health}, 4'd3);
      advanceFrames(2);
      checkOutput("postReset", 0, IDLE, 0, 3, 3, 0, 0, 0, 0, 0);

      // Give the monitor a bounded window to drain the scoreboard.
      for (int k = 0; k < 10 && expQ.size() != 0; k++) advanceFrames(1);
      while (expQ.size() != 0) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL %s: never compared, expected at frame %0d, now %0d",
                  expQ[0].name, expQ[0].frame, frameNo);
         void'(expQ.pop_front());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/match_controller.md
# match_controller

Round-level sequencer and hit arbiter for the two-fighter game, clocked by the 60 Hz frame tick. Takes per-player position, attack-phase and block indications from both fighter FSMs. Resolves hits, blocks and trades once per attack and tracks health. Drives `play_active`, per-player stun requests and the countdown/KO/game-over phase used by the renderer.

## Interface
- `SPRITE_W`, 64: sprite width in px; both sprites share it.
- `REACH`, 32: attack reach in px beyond the attacker's sprite edge.
- `MAX_HEALTH`, 3: health loaded at round start.
- `COUNTDOWN_FRAMES`, 180: frames spent in COUNTDOWN.
- `KO_FRAMES`, 120: frames spent in KO before GAME_OVER.
- `HITSTUN_FRAMES`, 16: stun length after an unblocked hit.
- `BLOCKSTUN_FRAMES`, 8: stun length after a blocked hit.

Ports:
- `clk`  in  1  60 Hz frame clock; the only clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  start/restart button, level.
- `p1_x`, `p2_x`  in  10  sprite top-left X; P1 is always left of P2.
- `p1_act`, `p2_act`  in  1  fighter is in its attack-active state.
- `p1_dir`, `p2_dir`  in  1  the current attack is directional; directional damage is 2, normal damage is 1.
- `p1_block`, `p2_block`  in  1  fighter is holding back (block).
- `play_active`  out  1  fighter FSMs may accept input.
- `phase`  out  3  IDLE=0, COUNTDOWN=1, FIGHT=2, KO=3, GAME_OVER=4.
- `p1_health`, `p2_health`  out  2  remaining health.
- `p1_hitstun`, `p2_hitstun`, `p1_blkstun`, `p2_blkstun`  out  1  stun requests to the fighter FSMs.
- `winner`  out  2  0=none, 1=P1, 2=P2, 3=draw.

## Operation
- **IDLE:** `start` goes to COUNTDOWN and loads both healths with MAX_HEALTH.
- **COUNTDOWN:** after COUNTDOWN_FRAMES frames, goes to FIGHT. `play_active`=1 only in FIGHT.
- **FIGHT, hit test:**
  - P1 connects when `p1_act` is high and `p1_x + SPRITE_W + REACH >= p2_x`.
  - P2 connects when `p2_act` is high and `p2_x <= p1_x + SPRITE_W + REACH`.
  - Compute both in 11 bits; no wrap.
- **One hit per attack:** each attacker has a `hit_done` latch. It sets on a connect and clears when `act` falls. Connects are ignored while it is set.
- **Connect resolution:**
  - Defender blocking: defender blockstun reloads to BLOCKSTUN_FRAMES; no damage.
  - Defender not blocking: health decrements by damage, saturating at 0, and hitstun reloads to HITSTUN_FRAMES.
  - A hit landing during an active stun reloads the counter; it does not add to it.
- **Simultaneous connects (trade):** both are resolved in the same frame, independently.
- **KO:** any health reaching 0 goes to KO.
  - `winner` is the surviving player, or 3 if both healths are 0 in the same frame.
  - Stun counters clear on entering KO.
- **KO to GAME_OVER:** after KO_FRAMES frames.
- **GAME_OVER:** `start` goes to COUNTDOWN with healths reloaded and `winner`=0.
- **`start` is ignored** in COUNTDOWN, FIGHT and KO.
- **Reset** at any point returns to IDLE with all counters and latches cleared.

## Timing
- All outputs are registered.
- Reset values: `phase`=IDLE, `play_active`=0, healths=MAX_HEALTH, all stun outputs=0, `winner`=0.
- A connect sampled at frame N:
  - Health and stun outputs update at N+1.
  - Stun stays high for exactly HITSTUN_FRAMES (or BLOCKSTUN_FRAMES) frames, N+1 through N+HITSTUN_FRAMES.
- Health reaching 0 at N+1: `phase`=KO and `play_active`=0 at N+2.
- `start` sampled at frame N in IDLE: `phase`=COUNTDOWN at N+1, FIGHT at N+1+COUNTDOWN_FRAMES.

## Configuration
- `MATCH_ROUND_TIMER_EN` defined:
  - Adds a 99-second round timer (5940 frames) that counts in FIGHT only.
  - Adds output `timer_sec` (7 bits), with reset value 99.
  - When the timer expires, goes to KO; the higher health wins, equal health gives `winner`=3.
  - A KO in the same frame as expiry takes priority.
- Undefined: no timer and no `timer_sec` port; rounds end only by KO.

## Structure
- Package `match_pkg`: `phase` encoding, `winner` encoding, damage constants (1 normal, 2 directional), timer frame count.
- Sub-module `stun_timer`, instantiated once per player:
  - A loadable down-counter with hit/block load inputs, hit taking priority.
  - A clear input.
  - Outputs `hitstun` and `blkstun`.

## Test plan
- Reset, pulse `start` -> COUNTDOWN for 180 frames, then FIGHT with `play_active`=1, healths=3.
- `p1_x`=100, `p2_x`=190, `p1_act` high 2 frames, `p1_dir`=0 -> `p2_health`=2 once, `p2_hitstun` high 16 frames.
- Same as above with `p2_block`=1 -> `p2_health` stays 3, `p2_blkstun` high 8 frames.
- `p2_x`=300 (out of reach), `p1_act` pulses -> no health or stun change.
- Both healths 1, both `act` high in the same frame, in reach -> both healths 0, KO, `winner`=3, GAME_OVER after 120 frames.
- Assert `reset` mid-FIGHT with P2 in hitstun -> next frame `phase`=IDLE, stun=0, healths=3.
